// File: rtl/key_pkg.sv
// key_debouncer shared definitions.
// Raw key polarity and default block sizing.
package key_pkg;

  // Raw button polarity as seen on the key pins.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Default bank width and qualification time
  // (20 ms at 400 MHz).
  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 8000000;

endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer key bank bundle.
// key: raw active-low buttons; keyVal: clean active-high levels.
interface key_debouncer_if
  import key_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS
);

  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] keyVal;

  // master: button side / consumer of clean levels.
  modport master (
    output key,
    input  keyVal
  );

  // slave: the debouncer itself.
  modport slave (
    input  key,
    output keyVal
  );

endinterface

// File: rtl/key_debounce_bit.sv
// key_debounce_bit: one key channel -- 2-flop sync, stability counter, stable level.
// Ports: clock, reset (sync, active-low), key_raw (async raw key), stable (raw polarity).
module key_debounce_bit
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1     <= KEY_RELEASED;
      s2     <= KEY_RELEASED;
      stable <= KEY_RELEASED;
      cnt    <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      // Any return to the accepted level throws
      // away the partial count; the commit edge
      // clears it too, so cnt never wraps.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: bank of independent key debouncers.
// Ports: clock, reset (sync, active-low), kb.key (raw, 0=pressed), kb.keyVal (1=pressed).
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            clock,
  input  logic            reset,
  key_debouncer_if.slave  kb
);

  logic [NUM_KEYS-1:0] stable;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clock   (clock),
      .reset   (reset),
      .key_raw (kb.key[i]),
      .stable  (stable[i])
    );

    // Pure decode of a flop: no path from key.
    assign kb.keyVal[i] = (stable[i] == KEY_PRESSED);
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench for key_debouncer.
// Directed test-plan sequences plus randomized key traffic.
module tb_key_debouncer;

  localparam int NK   = 4;
  localparam int D    = 4;
  localparam int MAXE = 8192;

  logic clk_400 = 1'b0;
  logic rst;

  key_debouncer_if #(.NUM_KEYS(NK)) kb ();

  key_debouncer #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock (clk_400),
    .reset (rst),
    .kb    (kb)
  );

  always #5 clk_400 = ~clk_400;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NK-1:0] exp_q [$];

  // Reference model: full input history by edge
  // number; a key's accepted level flips once the
  // synchronized input has disagreed with it on D
  // consecutive edges since its last change/reset.
  logic [NK-1:0] khist [0:MAXE];
  int            n          = 0;
  int            last_reset = 0;
  int            last_commit [NK];
  logic [NK-1:0] m_stable   = '1;
  bit            started    = 0;
  bit            done       = 0;

  int   edge_no = 0;
  int   rise0   = -1;
  int   fall0   = -1;
  logic prev0   = 1'b0;

  // Synchronizer output seen on edge e carries the
  // key sampled on edge e-2, or released if a reset
  // edge lies at or after that sample.
  function automatic logic sync_at(int e, int b);
    int s;
    s = e - 2;
    if (s < 1 || s <= last_reset) return 1'b1;
    return khist[s][b];
  endfunction

  task automatic chk(input string name,
                     input int got,
                     input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, want);
    end
  endtask

  task automatic step(input logic [NK-1:0] k,
                      input logic r);
    bit ok;
    int e;
    if (started) @(negedge clk_400);
    started = 1;
    kb.key = k;
    rst    = r;
    n++;
    if (n > MAXE) begin
      $display("FAIL edge_budget: got %0d, limit %0d",
               n, MAXE);
      $fatal(1);
    end
    khist[n] = k;
    if (!r) begin
      last_reset = n;
      m_stable   = '1;
      for (int b = 0; b < NK; b++) last_commit[b] = n;
    end else begin
      for (int b = 0; b < NK; b++) begin
        ok = 1;
        for (int j = 0; j < D; j++) begin
          e = n - j;
          if (e <= last_commit[b] || e <= last_reset ||
              sync_at(e, b) == m_stable[b])
            ok = 0;
        end
        if (ok) begin
          m_stable[b]    = ~m_stable[b];
          last_commit[b] = n;
        end
      end
    end
    exp_q.push_back(~m_stable);
  endtask

  task automatic hold(input logic [NK-1:0] k,
                      input int cycles);
    repeat (cycles) step(k, 1'b1);
  endtask

  // Monitor: one DUT output per clock edge.
  initial begin
    logic [NK-1:0] want;
    forever begin
      @(posedge clk_400);
      #1;
      edge_no++;
      if (kb.keyVal[0] === 1'b1 && prev0 !== 1'b1)
        rise0 = edge_no;
      if (kb.keyVal[0] === 1'b0 && prev0 === 1'b1)
        fall0 = edge_no;
      prev0 = kb.keyVal[0];
      if (exp_q.size() == 0) begin
        if (!done) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: edge %0d", edge_no);
        end
      end else begin
        want = exp_q.pop_front();
        n_checks++;
        if (kb.keyVal !== want) begin
          n_fail++;
          $display("FAIL keyVal@%0d: got %b, expected %b",
                   edge_no, kb.keyVal, want);
        end
      end
    end
  end

  initial begin
    int p;
    logic [NK-1:0] lvl;
    int left [NK];

    // Reset with all keys pressed.
    repeat (3) step(4'b0000, 1'b0);
    step(4'b1111, 1'b1);
    hold(4'b1111, 8);

    // Clean press / release on key 0.
    step(4'b1110, 1'b1);
    p = n;
    hold(4'b1110, 9);
    chk("press_latency", rise0 - p, D + 1);
    step(4'b1111, 1'b1);
    p = n;
    hold(4'b1111, 9);
    chk("release_latency", fall0 - p, D + 1);

    // Bounce on key 1 with 2-cycle dwell.
    hold(4'b1101, 2);
    hold(4'b1111, 2);
    hold(4'b1101, 2);
    hold(4'b1111, 2);
    hold(4'b1101, 10);
    hold(4'b1111, 10);

    // Glitches on key 2: D-1 then D cycles.
    hold(4'b1011, D - 1);
    hold(4'b1111, 10);
    hold(4'b1011, D);
    hold(4'b1111, 12);

    // Simultaneous then staggered keys 3 and 0.
    hold(4'b0110, 10);
    hold(4'b1111, 10);
    hold(4'b0111, 1);
    hold(4'b0110, 10);
    hold(4'b1111, 10);

    // Reset in the middle of a key 0 press.
    step(4'b1110, 1'b1);
    hold(4'b1110, 3);
    step(4'b1110, 1'b0);
    step(4'b1110, 1'b1);
    p = n;
    hold(4'b1110, 9);
    chk("reset_requal", rise0 - p, D + 1);
    hold(4'b1111, 10);

    // Random per-key hold times around D.
    lvl = 4'b1111;
    for (int b = 0; b < NK; b++) left[b] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NK; b++) begin
        left[b]--;
        if (left[b] <= 0) begin
          lvl[b]  = ~lvl[b];
          left[b] = $urandom_range(1, 2 * D + 2);
        end
      end
      if ($urandom_range(0, 299) == 0)
        step(lvl, 1'b0);
      else
        step(lvl, 1'b1);
    end

    @(posedge clk_400);
    #2;
    done = 1;
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Debounces and synchronises a bank of active-low mechanical push-buttons in the fast (400 MHz) clock domain.
- Outputs clean active-high "pressed" levels.
- Downstream logic rising-edge-detects these levels to step PWM period and scale.
- Each key is filtered independently by a per-key stability counter.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 8000000, consecutive clock cycles a new synchronised level must hold before it is accepted (20 ms at 400 MHz). Legal range is ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-key counter (derived; not for override).

Ports:
- clock, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-low reset: sampled on the clock edge, reset applied when it is 0.
- key, input, NUM_KEYS, raw asynchronous buttons; 0 = pressed, 1 = released.
- keyVal, output, NUM_KEYS, debounced registered level; 1 = pressed, 0 = released.

Behaviour:
- Reset (reset==0 at an edge):
  - sync stage 1 and stage 2 registers = all 1s;
  - stable state = all 1s (released);
  - all counters = 0;
  - keyVal = all 0s.
- Synchronizer: s1 <= key; s2 <= s1 (two flops per bit, no logic between them).
- Per bit i, every edge when not in reset:
  - if s2[i] == stable[i]: cnt[i] <= 0.
  - else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= s2[i]; cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- keyVal = ~stable, taken directly from the register (no combinational path from key).
- Latency:
  - Take the edge that first samples a new key level into s1 as edge 1.
  - A level held steadily appears on keyVal at edge DEBOUNCE_CYCLES+2.
  - Press and release have symmetric latency.
- Glitch rejection:
  - Any excursion of s2 lasting fewer than DEBOUNCE_CYCLES cycles leaves keyVal unchanged.
  - Each return to the stable level restarts the count from 0. There is no partial credit.
- Channels are fully independent. Simultaneous presses on several keys commit on the same edge if their timing is identical.
- Reset mid-count: the counter is cleared and stable returns to released. keyVal drops to 0 on the reset edge even if a key is held.
  - After reset is released with a key still held, the press is re-qualified: keyVal rises at edge DEBOUNCE_CYCLES+2 after the first non-reset edge.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- No X propagation: all registers are reset.

Decomposition:
- Shared package key_pkg holds:
  - KEY_PRESSED = 1'b0 and KEY_RELEASED = 1'b1 (raw polarity);
  - default NUM_KEYS;
  - default DEBOUNCE_CYCLES.
- One natural sub-module, key_debounce_bit: a single-channel synchronizer, counter and stable register with the same clock/reset and parameters DEBOUNCE_CYCLES/CNT_W.
- Top key_debouncer instantiates NUM_KEYS copies via generate and inverts the stable outputs.

Test Plan (DEBOUNCE_CYCLES=4, NUM_KEYS=4 unless stated):
- Reset: hold reset=0 for 3 edges with key=4'b0000 -> keyVal=4'b0000 during and on the first edge after release.
- Clean press: key=4'b1111, then key[0]=0 held -> keyVal[0] rises exactly on edge 6 (counting the first sampling edge), other bits stay 0; then key[0]=1 -> keyVal[0] falls on edge 6 after the change.
- Bounce: key[1] toggles 0,1,0,1 with 2-cycle dwell, then holds 0 -> keyVal[1] stays 0 during bouncing and rises 6 edges after the final settling edge.
- Glitch of 3 cycles (DEBOUNCE_CYCLES-1) on key[2] -> keyVal[2] never changes; glitch of 4 cycles -> keyVal[2] pulses high for a matching debounced interval.
- Simultaneous press on keys 3 and 0 on the same edge -> both keyVal bits rise on the same edge; staggered by 1 cycle -> they rise 1 edge apart.
- Reset mid-count: start a press on key[0], assert reset at count 2 -> keyVal[0]=0; release reset with key held -> keyVal[0] rises on edge 6 after the first non-reset edge.
